bus_irq_ctrl: RTL and testbench

BUS_IRQ_CTRL -- requirements
Module: bus_irq_ctrl

---
 rtl/bus_irq_ctrl.sv | 162 ++++++++++++++++
 tb/tb_bus_irq_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/bus_irq_ctrl.sv
// Bus-mapped interrupt controller: sticky per-channel STATUS, ENABLE/MODE masks,
// VECTOR readback and an irq output held off after each newly pending channel.
module bus_irq_ctrl #(
    parameter logic [31:0]           BUS_ADDR       = 32'h0,
    parameter int                    DATAWIDTH      = 32,
    parameter int                    HOLDOFF        = 15,
    parameter logic [DATAWIDTH-1:0]  MODE_RESET     = '0,
    localparam int                   BUS_ADDR_WIDTH = 32,
    localparam int                   BUS_DATA_WIDTH = 32,
    localparam int                   BUS_IN_WIDTH   = 2 + BUS_ADDR_WIDTH + BUS_DATA_WIDTH + 2,
    localparam int                   BUS_OUT_WIDTH  = BUS_DATA_WIDTH + 3
) (
    input  logic [BUS_IN_WIDTH-1:0]  bus_in,
    output logic [BUS_OUT_WIDTH-1:0] bus_out,
    input  logic [DATAWIDTH-1:0]     trig,
    output logic                     irq
);

    // bus_in = {bus_clk, bus_reset_l, addr, wr_data, rd_req, wr_req}
    logic                      w_bus_clk;
    logic                      w_bus_reset_l;
    logic [BUS_ADDR_WIDTH-1:0] w_addr;
    logic [BUS_DATA_WIDTH-1:0] w_wr_data;
    logic                      w_rd_req;
    logic                      w_wr_req;
    logic                      w_unused_bits;

    assign w_bus_clk     = bus_in[BUS_IN_WIDTH-1];
    assign w_bus_reset_l = bus_in[BUS_IN_WIDTH-2];
    assign w_addr        = bus_in[2+BUS_DATA_WIDTH +: BUS_ADDR_WIDTH];
    assign w_wr_data     = bus_in[2 +: BUS_DATA_WIDTH];
    assign w_rd_req      = bus_in[1];
    assign w_wr_req      = bus_in[0];
    assign w_unused_bits = ^{w_addr[1:0], w_wr_data};

    logic [DATAWIDTH-1:0]      r_status;
    logic [DATAWIDTH-1:0]      r_enable;
    logic [DATAWIDTH-1:0]      r_mode;
    logic [DATAWIDTH-1:0]      r_trig_prev;
    logic [DATAWIDTH-1:0]      r_pending;
    logic [7:0]                r_holdoff;
    logic                      r_irq;
    logic                      r_rd_ack;
    logic                      r_wr_ack;
    logic [BUS_DATA_WIDTH-1:0] r_rd_data;

    logic                      w_sel;
    logic [1:0]                w_reg;
    logic                      w_rd;
    logic                      w_wr;
    logic                      w_wr_status;
    logic                      w_wr_enable;
    logic                      w_wr_mode;

    assign w_sel       = ({w_addr[BUS_ADDR_WIDTH-1:4], 4'd0} == BUS_ADDR);
    assign w_reg       = w_addr[3:2];
    assign w_rd        = w_sel && w_rd_req;
    assign w_wr        = w_sel && w_wr_req;
    assign w_wr_status = w_wr && (w_reg == 2'd0);
    assign w_wr_enable = w_wr && (w_reg == 2'd1);
    assign w_wr_mode   = w_wr && (w_reg == 2'd2);

    logic [DATAWIDTH-1:0] w_set;
    logic [DATAWIDTH-1:0] w_clr;
    logic [DATAWIDTH-1:0] w_status_next;
    logic [DATAWIDTH-1:0] w_pending_next;
    logic                 w_new_pending;
    logic [7:0]           w_holdoff_next;

    // Edge channels only set when the previous trig sample was low; set beats W1C.
    assign w_set          = trig & ~(r_mode & r_trig_prev);
    assign w_clr          = w_wr_status ? w_wr_data[DATAWIDTH-1:0] : '0;
    assign w_status_next  = (r_status & ~w_clr) | w_set;
    assign w_pending_next = r_status & r_enable;
    assign w_new_pending  = |(w_pending_next & ~r_pending);

    always_comb begin
        w_holdoff_next = r_holdoff;
        if (w_new_pending) begin
            w_holdoff_next = 8'(HOLDOFF);
        end else if (r_holdoff != 8'd0) begin
            w_holdoff_next = r_holdoff - 8'd1;
        end
    end

    logic [4:0]                w_vec_idx;
    logic [BUS_DATA_WIDTH-1:0] w_vector;
    logic [BUS_DATA_WIDTH-1:0] w_rd_value;

    // Scanning downward leaves the lowest set pending index in w_vec_idx.
    always_comb begin
        w_vec_idx = 5'd0;
        for (int i = DATAWIDTH - 1; i >= 0; i--) begin
            if (r_pending[i]) begin
                w_vec_idx = 5'(i);
            end
        end
    end

    always_comb begin
        w_vector       = '0;
        w_vector[4:0]  = w_vec_idx;
        w_vector[31]   = |r_pending;
    end

    always_comb begin
        w_rd_value = '0;
        case (w_reg)
            2'd0:    w_rd_value[DATAWIDTH-1:0] = r_status;
            2'd1:    w_rd_value[DATAWIDTH-1:0] = r_enable;
            2'd2:    w_rd_value[DATAWIDTH-1:0] = r_mode;
            default: w_rd_value = w_vector;
        endcase
    end

    always_ff @(posedge w_bus_clk or negedge w_bus_reset_l) begin
        if (!w_bus_reset_l) begin
            r_status    <= '0;
            r_enable    <= '0;
            r_mode      <= MODE_RESET;
            r_trig_prev <= '0;
        end else begin
            r_trig_prev <= trig;
            r_status    <= w_status_next;
            if (w_wr_enable) begin
                r_enable <= w_wr_data[DATAWIDTH-1:0];
            end
            if (w_wr_mode) begin
                r_mode <= w_wr_data[DATAWIDTH-1:0];
            end
        end
    end

    always_ff @(posedge w_bus_clk or negedge w_bus_reset_l) begin
        if (!w_bus_reset_l) begin
            r_pending <= '0;
            r_holdoff <= 8'd0;
            r_irq     <= 1'b0;
        end else begin
            r_pending <= w_pending_next;
            r_holdoff <= w_holdoff_next;
            r_irq     <= (r_holdoff == 8'd0) && (|r_pending);
        end
    end

    always_ff @(posedge w_bus_clk or negedge w_bus_reset_l) begin
        if (!w_bus_reset_l) begin
            r_rd_ack  <= 1'b0;
            r_wr_ack  <= 1'b0;
            r_rd_data <= '0;
        end else begin
            r_rd_ack  <= w_rd;
            r_wr_ack  <= w_wr;
            r_rd_data <= w_rd ? w_rd_value : '0;
        end
    end

    // bus_out = {rd_data, rd_ack, wr_ack, irq field (unused, tied low)}
    assign bus_out = {r_rd_data, r_rd_ack, r_wr_ack, 1'b0};
    assign irq     = r_irq;

endmodule

// File: tb/tb_bus_irq_ctrl.sv
// Directed bench for bus_irq_ctrl: register access, edge/level capture, holdoff
// timing, vector readback and asynchronous reset behaviour.
module tb_bus_irq_ctrl;

    localparam logic [31:0] BASE     = 32'h40;
    localparam logic [31:0] STATUS_A = BASE;
    localparam logic [31:0] ENABLE_A = BASE + 32'd4;
    localparam logic [31:0] MODE_A   = BASE + 32'd8;
    localparam logic [31:0] VECTOR_A = BASE + 32'd12;

    logic        clock  = 1'b0;
    logic        resetL = 1'b1;
    logic        rdReq  = 1'b0;
    logic        wrReq  = 1'b0;
    logic [31:0] addr   = '0;
    logic [31:0] wrData = '0;
    logic [31:0] trig   = '0;
    logic [67:0] busIn;
    logic [34:0] busOut;
    logic        irq;

    int nAsserts = 0;
    int nFail    = 0;

    assign busIn = {clock, resetL, addr, wrData, rdReq, wrReq};

    always #5 clock = ~clock;

    bus_irq_ctrl #(
        .BUS_ADDR   (BASE),
        .DATAWIDTH  (32),
        .HOLDOFF    (15),
        .MODE_RESET (32'h0)
    ) dut (
        .bus_in  (busIn),
        .bus_out (busOut),
        .trig    (trig),
        .irq     (irq)
    );

    // Every comparison funnels through here so the counters stay consistent.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        nAsserts++;
        assert (observed === expected) else begin
            nFail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Drives one bus request cycle from a negedge and returns on the next negedge.
    task automatic applyStimulus(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
        rdReq  = r;
        wrReq  = w;
        addr   = a;
        wrData = d;
        @(negedge clock);
        rdReq  = 1'b0;
        wrReq  = 1'b0;
    endtask

    task automatic busWrite(input string tag, input logic [31:0] a, input logic [31:0] d, input logic expAck);
        applyStimulus(1'b0, 1'b1, a, d);
        checkOutput({tag, " wr_ack"}, {31'b0, busOut[1]}, {31'b0, expAck});
    endtask

    task automatic busRead(input string tag, input logic [31:0] a, input logic [31:0] expData, input logic expAck);
        applyStimulus(1'b1, 1'b0, a, 32'h0);
        checkOutput({tag, " rd_ack"}, {31'b0, busOut[2]}, {31'b0, expAck});
        checkOutput(tag, busOut[34:3], expData);
    endtask

    initial begin
        $display("[TB] start");
        #1 resetL = 1'b0;
        #2;
        checkOutput("reset rd_data", busOut[34:3], 32'h0);
        checkOutput("reset acks", {29'b0, busOut[2:0]}, 32'h0);
        checkOutput("reset irq", {31'b0, irq}, 32'h0);
        cycles(2);
        resetL = 1'b1;

        $display("[TB] level channel 0 and holdoff");
        busWrite("enable=1", ENABLE_A, 32'h1, 1'b1);
        trig[0] = 1'b1;
        cycles(1);
        trig[0] = 1'b0;
        cycles(16);
        checkOutput("ch0 holdoff last low", {31'b0, irq}, 32'h0);
        cycles(1);
        checkOutput("ch0 irq after holdoff", {31'b0, irq}, 32'h1);
        busRead("status after pulse", STATUS_A, 32'h1, 1'b1);
        cycles(1);
        checkOutput("idle rd_ack", {31'b0, busOut[2]}, 32'h0);
        checkOutput("idle rd_data", busOut[34:3], 32'h0);
        busWrite("w1c ch0", STATUS_A, 32'h1, 1'b1);
        cycles(1);
        checkOutput("irq one cycle after w1c", {31'b0, irq}, 32'h1);
        cycles(1);
        checkOutput("irq two cycles after w1c", {31'b0, irq}, 32'h0);
        busRead("enable readback", ENABLE_A, 32'h1, 1'b1);

        $display("[TB] decode and vector write");
        busWrite("miss write", BASE + 32'h14, 32'hFF, 1'b0);
        busRead("miss read", BASE + 32'h10, 32'h0, 1'b0);
        busRead("enable after miss", ENABLE_A, 32'h1, 1'b1);
        busWrite("vector write", VECTOR_A, 32'hFFFF_FFFF, 1'b1);
        busRead("vector idle", VECTOR_A, 32'h0, 1'b1);

        $display("[TB] edge channel 3");
        busWrite("mode=8", MODE_A, 32'h8, 1'b1);
        busRead("mode readback", MODE_A, 32'h8, 1'b1);
        trig[3] = 1'b1;
        cycles(10);
        busRead("edge set once", STATUS_A, 32'h8, 1'b1);
        cycles(37);
        busWrite("w1c ch3", STATUS_A, 32'h8, 1'b1);
        cycles(10);
        busRead("edge stays clear", STATUS_A, 32'h0, 1'b1);
        cycles(40);
        trig[3] = 1'b0;
        cycles(2);
        busRead("edge after release", STATUS_A, 32'h0, 1'b1);
        busWrite("mode=0", MODE_A, 32'h0, 1'b1);

        $display("[TB] set beats clear, partial w1c");
        trig[2] = 1'b1;
        cycles(3);
        busWrite("w1c ch2 while set", STATUS_A, 32'h4, 1'b1);
        trig[2] = 1'b0;
        busRead("set wins", STATUS_A, 32'h4, 1'b1);
        trig[1] = 1'b1;
        cycles(1);
        trig[1] = 1'b0;
        busWrite("w1c ch1 only", STATUS_A, 32'h2, 1'b1);
        busRead("partial w1c", STATUS_A, 32'h4, 1'b1);
        busWrite("w1c ch2", STATUS_A, 32'h4, 1'b1);
        busRead("status cleared", STATUS_A, 32'h0, 1'b1);

        $display("[TB] second channel restarts holdoff");
        busWrite("enable=3", ENABLE_A, 32'h3, 1'b1);
        trig[0] = 1'b1;
        cycles(1);
        trig[0] = 1'b0;
        cycles(17);
        checkOutput("ch0 irq high", {31'b0, irq}, 32'h1);
        trig[1] = 1'b1;
        cycles(1);
        trig[1] = 1'b0;
        cycles(1);
        checkOutput("irq before drop", {31'b0, irq}, 32'h1);
        cycles(1);
        checkOutput("irq drops on ch1", {31'b0, irq}, 32'h0);
        cycles(14);
        checkOutput("ch1 holdoff last low", {31'b0, irq}, 32'h0);
        cycles(1);
        checkOutput("irq reasserts", {31'b0, irq}, 32'h1);
        busRead("vector ch0", VECTOR_A, 32'h8000_0000, 1'b1);
        busWrite("w1c ch0 of two", STATUS_A, 32'h1, 1'b1);
        cycles(2);
        busRead("vector ch1", VECTOR_A, 32'h8000_0001, 1'b1);
        checkOutput("clear starts no holdoff", {31'b0, irq}, 32'h1);
        busWrite("w1c ch1", STATUS_A, 32'h2, 1'b1);
        cycles(1);
        checkOutput("irq before all-clear", {31'b0, irq}, 32'h1);
        cycles(1);
        checkOutput("irq after all-clear", {31'b0, irq}, 32'h0);

        $display("[TB] enable of already-set status");
        busWrite("enable=0", ENABLE_A, 32'h0, 1'b1);
        trig[4] = 1'b1;
        cycles(1);
        trig[4] = 1'b0;
        cycles(2);
        busRead("status ch4", STATUS_A, 32'h10, 1'b1);
        checkOutput("masked irq", {31'b0, irq}, 32'h0);
        busWrite("enable=0x10", ENABLE_A, 32'h10, 1'b1);
        cycles(16);
        checkOutput("enable holdoff last low", {31'b0, irq}, 32'h0);
        cycles(1);
        checkOutput("enable irq after holdoff", {31'b0, irq}, 32'h1);
        busRead("vector ch4", VECTOR_A, 32'h8000_0004, 1'b1);

        $display("[TB] reset mid-holdoff during read");
        trig[5] = 1'b1;
        cycles(1);
        trig[5] = 1'b0;
        busWrite("enable=0x30", ENABLE_A, 32'h30, 1'b1);
        rdReq = 1'b1;
        addr  = STATUS_A;
        @(negedge clock);
        checkOutput("pre-reset rd_ack", {31'b0, busOut[2]}, 32'h1);
        checkOutput("pre-reset irq", {31'b0, irq}, 32'h1);
        #2 resetL = 1'b0;
        #1;
        checkOutput("async rd_ack", {31'b0, busOut[2]}, 32'h0);
        checkOutput("async rd_data", busOut[34:3], 32'h0);
        checkOutput("async irq", {31'b0, irq}, 32'h0);
        trig[0] = 1'b1;
        cycles(2);
        rdReq  = 1'b0;
        resetL = 1'b1;
        cycles(1);
        trig[0] = 1'b0;
        checkOutput("no ack after release", {31'b0, busOut[2]}, 32'h0);
        checkOutput("irq after release", {31'b0, irq}, 32'h0);
        busRead("first edge sets status", STATUS_A, 32'h1, 1'b1);
        busRead("enable after reset", ENABLE_A, 32'h0, 1'b1);
        busRead("mode after reset", MODE_A, 32'h0, 1'b1);
        busRead("vector after reset", VECTOR_A, 32'h0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
        $finish;
    end

endmodule
